// File: rtl/irq_pend_pkg.sv
// Shared constants and helpers for the interrupt pending controller.
// The mip bit positions and the register-bus width are kept here so the CSR
// file and the pending controller agree on one definition.
package irq_pend_pkg;

    localparam int REG_BUS_W    = 32;
    localparam int MIP_MEIP_BIT = 11;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MSIP_BIT = 3;

    // Build the mip read value from the three pending sources; all other bits read 0.
    function automatic logic [REG_BUS_W-1:0] mip_pack(input logic meip,
                                                      input logic mtip,
                                                      input logic msip);
        logic [REG_BUS_W-1:0] v;
        v               = {REG_BUS_W{1'b0}};
        v[MIP_MEIP_BIT] = meip;
        v[MIP_MTIP_BIT] = mtip;
        v[MIP_MSIP_BIT] = msip;
        return v;
    endfunction

endpackage

// File: rtl/irq_pend_sync.sv
// Multi-flop synchroniser for a single asynchronous level, with synchronous reset.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/irq_pend.sv
// Interrupt pending controller: synchronises the external IRQ pin, latches it
// edge- or level-triggered, registers the timer and software levels, and masks
// all three with the mie bits for the trap unit. The unmasked view feeds mip.
// Optional glitch filter on the external pin: define IRQ_GLITCH_FILTER_EN.
module irq_pend
    import irq_pend_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_irq_i,
    input  logic                 tcmp_irq_i,
    input  logic                 soft_irq_i,
    input  logic                 ex_edge_mode_i,
    input  logic                 meie_i,
    input  logic                 mtie_i,
    input  logic                 msie_i,
    input  logic                 pex_rsp_i,
    input  logic                 ptcmp_rsp_i,
    input  logic                 psoft_rsp_i,
    input  logic                 ovr_clr_i,
    output logic                 pex_trap_o,
    output logic                 ptcmp_trap_o,
    output logic                 psoft_trap_o,
    output logic [REG_BUS_W-1:0] mip_o,
    output logic                 ex_ovr_o
);

    // Reject illegal parameter values at elaboration time.
    if (SYNC_STAGES < 2 || FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_param
        $error("irq_pend: SYNC_STAGES must be >=2 and FILT_CYC must be 1..255");
    end

    logic ex_s;
    logic ex_f;
    logic ex_l_r;
    logic ex_e_r;
    logic tm_p_r;
    logic sw_p_r;
    logic ovr_r;
    logic ex_set_s;
    logic meip_s;

    // Timer and software sources are levels; the trap unit's responses for them carry no state here.
    logic unused_rsp_s;
    assign unused_rsp_s = ptcmp_rsp_i ^ psoft_rsp_i;

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ex_sync (
        .clk (clk),
        .rst (rst),
        .d   (ex_irq_i),
        .q   (ex_s)
    );

`ifdef IRQ_GLITCH_FILTER_EN
    localparam int                CNT_W    = $clog2(FILT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [CNT_W-1:0] filt_cnt_r;
    logic             ex_f_r;

    // Accept a new pin level only after it has differed from the filtered level for FILT_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_r <= {CNT_W{1'b0}};
            ex_f_r     <= 1'b0;
        end else if (ex_s == ex_f_r) begin
            filt_cnt_r <= {CNT_W{1'b0}};
            ex_f_r     <= ex_f_r;
        end else if (filt_cnt_r == CNT_LAST) begin
            filt_cnt_r <= {CNT_W{1'b0}};
            ex_f_r     <= ex_s;
        end else begin
            filt_cnt_r <= filt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            ex_f_r     <= ex_f_r;
        end
    end

    assign ex_f = ex_f_r;
`else
    assign ex_f = ex_s;
`endif

    // A rising edge of the filtered pin is only meaningful in edge mode.
    assign ex_set_s = ex_edge_mode_i & ex_f & ~ex_l_r;

    // Level copies of the three sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_l_r <= 1'b0;
            tm_p_r <= 1'b0;
            sw_p_r <= 1'b0;
        end else begin
            ex_l_r <= ex_f;
            tm_p_r <= tcmp_irq_i;
            sw_p_r <= soft_irq_i;
        end
    end

    // Edge-pending flag: a new edge beats a simultaneous response so no edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_e_r <= 1'b0;
        end else if (!ex_edge_mode_i) begin
            ex_e_r <= 1'b0;
        end else if (ex_set_s) begin
            ex_e_r <= 1'b1;
        end else if (pex_rsp_i) begin
            ex_e_r <= 1'b0;
        end else begin
            ex_e_r <= ex_e_r;
        end
    end

    // Sticky overrun: an edge landed on an already-pending, unserviced interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_r <= 1'b0;
        end else if (ex_set_s && ex_e_r && !pex_rsp_i) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr_i) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    // Masks apply combinationally so a mie write takes effect in the same cycle.
    always_comb begin
        meip_s       = ex_edge_mode_i ? ex_e_r : ex_l_r;
        pex_trap_o   = meip_s & meie_i;
        ptcmp_trap_o = tm_p_r & mtie_i;
        psoft_trap_o = sw_p_r & msie_i;
        mip_o        = mip_pack(meip_s, tm_p_r, sw_p_r);
        ex_ovr_o     = ovr_r;
    end

endmodule

// File: tb/tb_irq_pend.sv
// Directed self-checking bench for irq_pend (SYNC_STAGES=2, FILT_CYC=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_irq_pend;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_irq_i, tcmp_irq_i, soft_irq_i, ex_edge_mode_i;
    logic        meie_i, mtie_i, msie_i;
    logic        pex_rsp_i, ptcmp_rsp_i, psoft_rsp_i, ovr_clr_i;
    logic        pex_trap_o, ptcmp_trap_o, psoft_trap_o, ex_ovr_o;
    logic [31:0] mip_o;

    int checks = 0;
    int errors = 0;

    irq_pend #(.SYNC_STAGES(2), .FILT_CYC(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_irq_i       (ex_irq_i),
        .tcmp_irq_i     (tcmp_irq_i),
        .soft_irq_i     (soft_irq_i),
        .ex_edge_mode_i (ex_edge_mode_i),
        .meie_i         (meie_i),
        .mtie_i         (mtie_i),
        .msie_i         (msie_i),
        .pex_rsp_i      (pex_rsp_i),
        .ptcmp_rsp_i    (ptcmp_rsp_i),
        .psoft_rsp_i    (psoft_rsp_i),
        .ovr_clr_i      (ovr_clr_i),
        .pex_trap_o     (pex_trap_o),
        .ptcmp_trap_o   (ptcmp_trap_o),
        .psoft_trap_o   (psoft_trap_o),
        .mip_o          (mip_o),
        .ex_ovr_o       (ex_ovr_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ex_irq_i = 1'b0; tcmp_irq_i = 1'b0; soft_irq_i = 1'b0;
        ex_edge_mode_i = 1'b0; meie_i = 1'b0; mtie_i = 1'b0; msie_i = 1'b0;
        pex_rsp_i = 1'b0; ptcmp_rsp_i = 1'b0; psoft_rsp_i = 1'b0; ovr_clr_i = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_pex", {31'd0, pex_trap_o}, 32'd0);
        chk("rst_mip", mip_o, 32'd0);
        chk("rst_ovr", {31'd0, ex_ovr_o}, 32'd0);

        // Test 1: edge mode latency and response clear
        ex_edge_mode_i = 1'b1; meie_i = 1'b1; mtie_i = 1'b1; msie_i = 1'b1;
        ex_irq_i = 1'b1;
        tick(2);
        chk("t1_early", {31'd0, pex_trap_o}, 32'd0);
        tick(1);
        chk("t1_pex", {31'd0, pex_trap_o}, 32'd1);
        chk("t1_mip", mip_o, 32'h800);
        tick(2);
        chk("t1_hold", {31'd0, pex_trap_o}, 32'd1);
        pex_rsp_i = 1'b1; tick(1); pex_rsp_i = 1'b0;
        chk("t1_rsp_clr", {31'd0, pex_trap_o}, 32'd0);
        chk("t1_mip_clr", mip_o, 32'd0);

        // Test 2: overrun, overrun clear, edge coincident with response
        ex_irq_i = 1'b0; tick(3);
        ex_irq_i = 1'b1; tick(3);
        chk("t2_pend", {31'd0, pex_trap_o}, 32'd1);
        chk("t2_no_ovr", {31'd0, ex_ovr_o}, 32'd0);
        ex_irq_i = 1'b0; tick(3);
        ex_irq_i = 1'b1; tick(3);
        chk("t2_ovr", {31'd0, ex_ovr_o}, 32'd1);
        chk("t2_pend2", {31'd0, pex_trap_o}, 32'd1);
        ovr_clr_i = 1'b1; tick(1); ovr_clr_i = 1'b0;
        chk("t2_ovr_clr", {31'd0, ex_ovr_o}, 32'd0);
        chk("t2_pend3", {31'd0, pex_trap_o}, 32'd1);
        ex_irq_i = 1'b0; tick(3);
        ex_irq_i = 1'b1; tick(2);
        pex_rsp_i = 1'b1; tick(1); pex_rsp_i = 1'b0;
        chk("t2_set_wins", {31'd0, pex_trap_o}, 32'd1);
        chk("t2_rsp_no_ovr", {31'd0, ex_ovr_o}, 32'd0);
        pex_rsp_i = 1'b1; tick(1); pex_rsp_i = 1'b0;
        chk("t2_final_clr", {31'd0, pex_trap_o}, 32'd0);

        // Test 3: mode switch clears edge pending, then level mode behaviour
        ex_irq_i = 1'b0; tick(3);
        ex_irq_i = 1'b1; tick(3);
        ex_irq_i = 1'b0; tick(3);
        chk("t3_edge_latched", {31'd0, pex_trap_o}, 32'd1);
        ex_edge_mode_i = 1'b0; tick(1);
        ex_edge_mode_i = 1'b1; #1;
        chk("t3_mode_clear", {31'd0, pex_trap_o}, 32'd0);
        ex_edge_mode_i = 1'b0;
        ex_irq_i = 1'b1; tick(3);
        chk("t3_lvl_pex", {31'd0, pex_trap_o}, 32'd1);
        chk("t3_lvl_mip", mip_o, 32'h800);
        meie_i = 1'b0; #1;
        chk("t3_meie0", {31'd0, pex_trap_o}, 32'd0);
        chk("t3_meie0_mip", mip_o, 32'h800);
        meie_i = 1'b1; #1;
        chk("t3_meie1", {31'd0, pex_trap_o}, 32'd1);
        pex_rsp_i = 1'b1; tick(1); pex_rsp_i = 1'b0;
        chk("t3_rsp_noeff", {31'd0, pex_trap_o}, 32'd1);
        ex_irq_i = 1'b0; tick(2);
        chk("t3_low_early", {31'd0, pex_trap_o}, 32'd1);
        tick(1);
        chk("t3_low", {31'd0, pex_trap_o}, 32'd0);
        chk("t3_low_mip", mip_o, 32'd0);

        // Test 4: timer/software masking, then reset mid-operation
        ex_edge_mode_i = 1'b1;
        ex_irq_i = 1'b1; tick(3);
        ex_irq_i = 1'b0; tick(3);
        ex_irq_i = 1'b1; tick(3);
        chk("t4_ovr_pre", {31'd0, ex_ovr_o}, 32'd1);
        ex_irq_i = 1'b0; pex_rsp_i = 1'b1; tick(1); pex_rsp_i = 1'b0;
        tcmp_irq_i = 1'b1; soft_irq_i = 1'b1; mtie_i = 1'b1; msie_i = 1'b0;
        tick(1);
        chk("t4_ptcmp", {31'd0, ptcmp_trap_o}, 32'd1);
        chk("t4_psoft", {31'd0, psoft_trap_o}, 32'd0);
        chk("t4_mip", mip_o, 32'h88);
        msie_i = 1'b1; #1;
        chk("t4_msie1", {31'd0, psoft_trap_o}, 32'd1);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("t4_rst_ptcmp", {31'd0, ptcmp_trap_o}, 32'd0);
        chk("t4_rst_psoft", {31'd0, psoft_trap_o}, 32'd0);
        chk("t4_rst_mip", mip_o, 32'd0);
        chk("t4_rst_ovr", {31'd0, ex_ovr_o}, 32'd0);
        tick(1);
        chk("t4_after_rst", {31'd0, ptcmp_trap_o}, 32'd1);
        tcmp_irq_i = 1'b0; soft_irq_i = 1'b0;

        // Test 5: short and long pulses, with and without the glitch filter
        rst = 1'b1; tick(1); rst = 1'b0;
        ex_edge_mode_i = 1'b1; meie_i = 1'b1;
        tick(3);
`ifdef IRQ_GLITCH_FILTER_EN
        ex_irq_i = 1'b1; tick(3);
        ex_irq_i = 1'b0; tick(8);
        chk("t5_short_pex", {31'd0, pex_trap_o}, 32'd0);
        chk("t5_short_mip", mip_o, 32'd0);
        ex_irq_i = 1'b1; tick(6);
        ex_irq_i = 1'b0;
        chk("t5_long_early", {31'd0, pex_trap_o}, 32'd0);
        tick(1);
        chk("t5_long_pex", {31'd0, pex_trap_o}, 32'd1);
`else
        ex_irq_i = 1'b1; tick(3);
        ex_irq_i = 1'b0;
        chk("t5_nofilt_short", {31'd0, pex_trap_o}, 32'd1);
        tick(8);
        chk("t5_nofilt_hold", {31'd0, pex_trap_o}, 32'd1);
        chk("t5_nofilt_mip", mip_o, 32'h800);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
